mem_stage_access: RTL and testbench
===================================

# mem_stage_access

Parametrised successor to the pipeline's data-memory stage. Performs byte-addressed byte, halfword and word loads and stores into an internal data memory. Places sub-word stores in the correct byte lane, with sign or zero extension on loads. Accesses run through a request/done handshake with a configurable number of wait states, so the core can stall on a slow memory model; misaligned accesses are detected.

## Interface
- IO_BUS_SIZE, 32, data word width in bits; power of two, ≥ 32
- MEM_ADDR_SIZE, 5, log2 of memory depth in words
- WAIT_CYCLES, 0, extra access cycles inserted before each memory access (0..255)
- i_clk  in  1  clock; all state changes on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_req  in  1  start access; sampled only in IDLE or DONE
- i_mem_wr_rd  in  1  1 = store, 0 = load
- i_size  in  2  00 byte, 01 halfword (16 b), 10 word (IO_BUS_SIZE), 11 treated as word
- i_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend; ignored for word and stores
- i_alu_res  in  IO_BUS_SIZE  byte address
- i_bus_b  in  IO_BUS_SIZE  store data, right-justified
- o_busy  out  1  high while state is ACCESS
- o_done  out  1  single-cycle completion pulse
- o_mem_rd  out  IO_BUS_SIZE  registered, extended load result; held until next completion
- o_alu_result  out  IO_BUS_SIZE  address captured at request; held until next request
- o_misaligned  out  1  registered; valid with o_done
- o_bus_debug  out  2**MEM_ADDR_SIZE*IO_BUS_SIZE  memory image, word 0 in the LSBs

## Operation
- OFF = log2(IO_BUS_SIZE/8). Word index = addr[MEM_ADDR_SIZE+OFF-1:OFF]. Upper address bits are ignored, so addresses wrap modulo the memory size. Lane = addr[OFF-1:0]. Byte order is little-endian.
- FSM states are IDLE, ACCESS and DONE.
- IDLE, or DONE, with i_req high:
  - capture address, data, size, signedness and direction
  - load counter with WAIT_CYCLES
  - go to ACCESS
- DONE with i_req low: go to IDLE.
- ACCESS with counter ≠ 0: decrement the counter.
- ACCESS with counter = 0:
  - perform the access and register the results
  - go to DONE
- Store: write only the addressed lanes (1 byte, 2 bytes or the full word); all other bytes are preserved. Store data comes from the low bits of i_bus_b.
- Load:
  - select the addressed lanes and right-justify them
  - extend to IO_BUS_SIZE according to i_unsigned
- i_req while in ACCESS is ignored; no queueing.
- Misaligned means a halfword with addr[0] = 1, or a word with addr[OFF-1:0] ≠ 0.

## Timing
- Reset: every output goes to 0, the FSM goes to IDLE, the counter goes to 0, and every memory word is cleared asynchronously.
- Reset mid-ACCESS aborts the operation: no write happens and no o_done is issued.
- Latency: i_req accepted in cycle N; o_done high in cycle N+WAIT_CYCLES+2; o_busy high for cycles N+1 .. N+WAIT_CYCLES+1.
- The memory write and the o_mem_rd/o_misaligned update happen on the same edge, the one that enters DONE.
- A load issued right after a store to the same word returns the new data.
- Back-to-back: i_req during DONE restarts immediately. Sustained throughput is one access every WAIT_CYCLES+2 cycles.
- o_mem_rd is unchanged by stores.

## Configuration
- MEM_STAGE_MISALIGN_TRAP_EN defined:
  - a misaligned access completes with normal latency
  - o_misaligned = 1 and o_mem_rd = 0
  - nothing is written to memory
- MEM_STAGE_MISALIGN_TRAP_EN undefined:
  - the low address bits are forced to the alignment of the size (halfword clears bit 0, word clears bits OFF-1:0)
  - the access proceeds normally
  - o_misaligned is tied to 0

## Test plan
Defaults (32/5/0) unless stated.
- Word store 0xDEADBEEF at 0x10, then word load at 0x10 → o_mem_rd = 0xDEADBEEF; o_done at N+2; o_bus_debug word 4 = 0xDEADBEEF.
- After the first test, byte store of i_bus_b = 0x123456A5 at 0x13:
  - word load at 0x10 → 0xA5ADBEEF
  - signed byte load at 0x13 → 0xFFFFFFA5
  - unsigned byte load at 0x13 → 0x000000A5
- Word 0xDEADBEEF at 0x10, then halfword store 0x1234 at 0x12:
  - word load → 0x1234BEEF
  - signed halfword load at 0x10 → 0xFFFFBEEF
  - unsigned halfword load at 0x10 → 0x0000BEEF
- Word load at 0x11:
  - with the macro → o_misaligned = 1, o_mem_rd = 0
  - with the macro, a word store at 0x11 leaves word 4 unchanged
  - without the macro → reads word 4, o_misaligned = 0
- WAIT_CYCLES = 3, three parts:
  - o_busy is high for 4 cycles; o_done at N+5
  - an i_req pulse during ACCESS is ignored
  - i_reset pulsed mid-ACCESS of a store → no o_done, all outputs 0, o_bus_debug all zero
- Wrap-around and back-to-back:
  - word store 0xCAFEF00D at 0x90 → lands in word 4
  - a load of 0x10 requested in the DONE cycle → 0xCAFEF00D, done 2 cycles later

Source files
------------

// File: rtl/mem_stage_access.sv
// Data-memory stage: byte/halfword/word loads and stores through a req/done handshake with WAIT_CYCLES wait states.
// Optional MEM_STAGE_MISALIGN_TRAP_EN: misaligned accesses are flagged and suppressed instead of force-aligned.
//   state  | meaning
//   IDLE   | waiting for i_req
//   ACCESS | counting down wait states, then performing the access
//   DONE   | o_done pulse; a new i_req restarts immediately
module mem_stage_access #(
  parameter int IO_BUS_SIZE   = 32,
  parameter int MEM_ADDR_SIZE = 5,
  parameter int WAIT_CYCLES   = 0
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic                                    i_req,
  input  logic                                    i_mem_wr_rd,
  input  logic [1:0]                              i_size,
  input  logic                                    i_unsigned,
  input  logic [IO_BUS_SIZE-1:0]                  i_alu_res,
  input  logic [IO_BUS_SIZE-1:0]                  i_bus_b,
  output logic                                    o_busy,
  output logic                                    o_done,
  output logic [IO_BUS_SIZE-1:0]                  o_mem_rd,
  output logic [IO_BUS_SIZE-1:0]                  o_alu_result,
  output logic                                    o_misaligned,
  output logic [2**MEM_ADDR_SIZE*IO_BUS_SIZE-1:0] o_bus_debug
);

  localparam int NB    = IO_BUS_SIZE / 8;
  localparam int OFF   = $clog2(NB);
  localparam int DEPTH = 2**MEM_ADDR_SIZE;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                   state, state_nxt;
  logic [7:0]               cnt;
  logic [IO_BUS_SIZE-1:0]   data_q;
  logic [1:0]               size_q;
  logic                     uns_q;
  logic                     wr_q;
  logic [IO_BUS_SIZE-1:0]   mem [DEPTH];

  logic                     accept;
  logic                     fire;
  logic                     trap;
  logic                     do_write;
  logic [MEM_ADDR_SIZE-1:0] word_idx;
  logic [OFF-1:0]           lane;
  logic [OFF-1:0]           lane_eff;
  logic [OFF+2:0]           shamt;
  logic [NB-1:0]            byte_en;
  logic [IO_BUS_SIZE-1:0]   cur_word;
  logic [IO_BUS_SIZE-1:0]   wr_shift;
  logic [IO_BUS_SIZE-1:0]   wr_word;
  logic [IO_BUS_SIZE-1:0]   rd_shift;
  logic [IO_BUS_SIZE-1:0]   rd_ext;

  assign accept = i_req && (state == IDLE || state == DONE);
  assign fire   = (state == ACCESS) && (cnt == 8'd0);
  assign o_busy = (state == ACCESS);
  assign o_done = (state == DONE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 8'd0) state_nxt = DONE;
      DONE:    state_nxt = i_req ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign word_idx = o_alu_result[MEM_ADDR_SIZE+OFF-1:OFF];
  assign lane     = o_alu_result[OFF-1:0];
  assign cur_word = mem[word_idx];

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign trap     = ((size_q == 2'b01) && lane[0]) || (size_q[1] && (lane != '0));
  assign lane_eff = lane;
`else
  assign trap     = 1'b0;
  // Without the trap, low address bits are dropped to the natural alignment of the size.
  assign lane_eff = size_q[1]          ? '0 :
                    (size_q == 2'b01)  ? {lane[OFF-1:1], 1'b0} : lane;
`endif

  assign shamt    = {lane_eff, 3'b000};
  assign wr_shift = data_q << shamt;
  assign rd_shift = cur_word >> shamt;
  assign do_write = fire && wr_q && !trap;

  always_comb begin
    byte_en = '1;
    if (size_q == 2'b00)      byte_en = {{(NB-1){1'b0}}, 1'b1} << lane_eff;
    else if (size_q == 2'b01) byte_en = {{(NB-2){1'b0}}, 2'b11} << lane_eff;
    wr_word = cur_word;
    for (int b = 0; b < NB; b++)
      if (byte_en[b]) wr_word[b*8 +: 8] = wr_shift[b*8 +: 8];
  end

  always_comb begin
    rd_ext = rd_shift;
    if (size_q == 2'b00)
      rd_ext = {{(IO_BUS_SIZE-8){~uns_q & rd_shift[7]}}, rd_shift[7:0]};
    else if (size_q == 2'b01)
      rd_ext = {{(IO_BUS_SIZE-16){~uns_q & rd_shift[15]}}, rd_shift[15:0]};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[word_idx] <= wr_word;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt          <= 8'd0;
      data_q       <= '0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      wr_q         <= 1'b0;
      o_alu_result <= '0;
      o_mem_rd     <= '0;
      o_misaligned <= 1'b0;
    end else if (accept) begin
      cnt          <= 8'(WAIT_CYCLES);
      data_q       <= i_bus_b;
      size_q       <= i_size;
      uns_q        <= i_unsigned;
      wr_q         <= i_mem_wr_rd;
      o_alu_result <= i_alu_res;
    end else if (state == ACCESS) begin
      if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end else begin
        o_misaligned <= trap;
        if (trap)       o_mem_rd <= '0;
        else if (!wr_q) o_mem_rd <= rd_ext;
      end
    end
  end

  always_comb begin
    o_bus_debug = '0;
    for (int i = 0; i < DEPTH; i++) o_bus_debug[i*IO_BUS_SIZE +: IO_BUS_SIZE] = mem[i];
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: vector table on a zero-wait instance, hand sequences on a WAIT_CYCLES=3 instance.
module tb_mem_stage_access;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // zero-wait instance
  logic         rst0 = 1'b0, req0 = 1'b0, wr0 = 1'b0, uns0 = 1'b0;
  logic [1:0]   size0 = 2'b00;
  logic [31:0]  addr0 = '0, data0 = '0;
  logic         busy0, done0, mis0;
  logic [31:0]  rd0, alu0;
  logic [1023:0] dbg0;

  mem_stage_access #(.IO_BUS_SIZE(32), .MEM_ADDR_SIZE(5), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset(rst0), .i_req(req0), .i_mem_wr_rd(wr0), .i_size(size0),
    .i_unsigned(uns0), .i_alu_res(addr0), .i_bus_b(data0), .o_busy(busy0), .o_done(done0),
    .o_mem_rd(rd0), .o_alu_result(alu0), .o_misaligned(mis0), .o_bus_debug(dbg0));

  // three-wait instance
  logic         rst1 = 1'b0, req1 = 1'b0, wr1 = 1'b0, uns1 = 1'b0;
  logic [1:0]   size1 = 2'b10;
  logic [31:0]  addr1 = '0, data1 = '0;
  logic         busy1, done1, mis1;
  logic [31:0]  rd1, alu1;
  logic [1023:0] dbg1;

  mem_stage_access #(.IO_BUS_SIZE(32), .MEM_ADDR_SIZE(5), .WAIT_CYCLES(3)) dut1 (
    .i_clk(clk), .i_reset(rst1), .i_req(req1), .i_mem_wr_rd(wr1), .i_size(size1),
    .i_unsigned(uns1), .i_alu_res(addr1), .i_bus_b(data1), .o_busy(busy1), .o_done(done1),
    .o_mem_rd(rd1), .o_alu_result(alu1), .o_misaligned(mis1), .o_bus_debug(dbg1));

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        dbg_en;
    logic [31:0] dbg_w4;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] exp_rd, input logic exp_mis,
                              input logic dbg_en, input logic [31:0] dbg_w4);
    vec_t v;
    v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.data = data;
    v.exp_rd = exp_rd; v.exp_mis = exp_mis; v.dbg_en = dbg_en; v.dbg_w4 = dbg_w4;
    return v;
  endfunction

  // Caller is positioned at a negedge; returns at the negedge where o_done is seen.
  task automatic access0(input vec_t v, input string tag);
    int lat;
    lat = 0;
    wr0 = v.wr; size0 = v.size; uns0 = v.uns; addr0 = v.addr; data0 = v.data; req0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req0 = 1'b0;
      if (done0) begin lat = k; break; end
    end
    check({tag, " latency"}, lat, 2);
    check({tag, " o_mem_rd"}, rd0, v.exp_rd);
    check({tag, " o_misaligned"}, {31'd0, mis0}, {31'd0, v.exp_mis});
    check({tag, " o_alu_result"}, alu0, v.addr);
    if (v.dbg_en) check({tag, " debug word4"}, dbg0[4*32 +: 32], v.dbg_w4);
  endtask

  // abort_k > 0 pulses reset at that cycle after acceptance; a second i_req is pulsed at pulse_k.
  task automatic run1(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input int pulse_k, input int abort_k, output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    wr1 = wr; size1 = 2'b10; uns1 = 1'b0; addr1 = addr; data1 = data; req1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req1 = (k == pulse_k);
      if (k == pulse_k) begin addr1 = 32'h0000_0008; wr1 = 1'b0; end
      if (k == abort_k) begin
        #1 rst1 = 1'b1;
        #2 rst1 = 1'b0;
        break;
      end
      if (busy1) nbusy++;
      if (done1) begin lat = k; break; end
    end
    req1 = 1'b0;
  endtask

  int lat, nbusy, extra;

  initial begin
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    vt[11] = mk(1'b0, 2'b10, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0);
    vt[12] = mk(1'b1, 2'b10, 1'b0, 32'h11, 32'h55555555, 32'h0,        1'b1, 1'b1, 32'h1234BEEF);
    vt[13] = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h1234BEEF, 1'b0, 1'b0, 32'h0);
    vt[14] = mk(1'b0, 2'b01, 1'b1, 32'h13, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0);
    vt[15] = mk(1'b1, 2'b10, 1'b0, 32'h90, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D);
`else
    vt[11] = mk(1'b0, 2'b10, 1'b0, 32'h11, 32'h0,        32'h1234BEEF, 1'b0, 1'b0, 32'h0);
    vt[12] = mk(1'b1, 2'b10, 1'b0, 32'h11, 32'h55555555, 32'h1234BEEF, 1'b0, 1'b1, 32'h55555555);
    vt[13] = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h55555555, 1'b0, 1'b0, 32'h0);
    vt[14] = mk(1'b0, 2'b01, 1'b1, 32'h13, 32'h0,        32'h00005555, 1'b0, 1'b0, 32'h0);
    vt[15] = mk(1'b1, 2'b10, 1'b0, 32'h90, 32'hCAFEF00D, 32'h00005555, 1'b0, 1'b1, 32'hCAFEF00D);
`endif
    vt[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
    vt[1]  = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    vt[2]  = mk(1'b1, 2'b00, 1'b0, 32'h13, 32'h123456A5, 32'hDEADBEEF, 1'b0, 1'b1, 32'hA5ADBEEF);
    vt[3]  = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hA5ADBEEF, 1'b0, 1'b0, 32'h0);
    vt[4]  = mk(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFFA5, 1'b0, 1'b0, 32'h0);
    vt[5]  = mk(1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h000000A5, 1'b0, 1'b0, 32'h0);
    vt[6]  = mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h000000A5, 1'b0, 1'b1, 32'hDEADBEEF);
    vt[7]  = mk(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 32'h000000A5, 1'b0, 1'b1, 32'h1234BEEF);
    vt[8]  = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h1234BEEF, 1'b0, 1'b0, 32'h0);
    vt[9]  = mk(1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 1'b0, 32'h0);
    vt[10] = mk(1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 1'b0, 32'h0);

    #2 rst0 = 1'b1; rst1 = 1'b1;
    repeat (2) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;

    check("reset o_busy/o_done", {30'd0, busy0, done0}, 32'd0);
    check("reset o_mem_rd", rd0, 32'd0);
    check("reset o_alu_result", alu0, 32'd0);
    check("reset o_misaligned", {31'd0, mis0}, 32'd0);
    check("reset debug zero", {31'd0, dbg0 == '0}, 32'd1);

    foreach (vt[i]) begin
      @(negedge clk);
      access0(vt[i], $sformatf("vec%0d", i));
    end

    // back-to-back: request issued in the DONE cycle of the previous access
    access0(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 32'hCAFEF00D), "b2b load");
    @(negedge clk);
    check("idle after done", {30'd0, busy0, done0}, 32'd0);

    // wait-state instance: latency, busy width, ignored mid-access request
    @(negedge clk);
    run1(1'b1, 32'h04, 32'h11112222, 2, 0, lat, nbusy);
    check("w3 store latency", lat, 5);
    check("w3 store busy cycles", nbusy, 4);
    check("w3 alu held", alu1, 32'h04);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy1 || done1) extra++;
    end
    check("w3 ignored req", extra, 0);

    run1(1'b0, 32'h04, 32'h0, 0, 0, lat, nbusy);
    check("w3 load latency", lat, 5);
    check("w3 load data", rd1, 32'h11112222);
    check("w3 debug word1", dbg1[1*32 +: 32], 32'h11112222);

    // reset in the middle of a store
    @(negedge clk);
    run1(1'b1, 32'h0C, 32'h77777777, 0, 2, lat, nbusy);
    check("abort outputs", {28'd0, busy1, done1, mis1, 1'b0}, 32'd0);
    check("abort o_mem_rd", rd1, 32'd0);
    check("abort o_alu_result", alu1, 32'd0);
    check("abort debug zero", {31'd0, dbg1 == '0}, 32'd1);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done1 || busy1) extra++;
    end
    check("abort no done", extra, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
